multi_lifo: RTL and testbench

MULTI_LIFO -- requirements
Module: multi_lifo

---
 rtl/multi_lifo_pkg.sv | 41 ++++
 rtl/multi_lifo_ram.sv | 36 +++
 rtl/multi_lifo.sv | 163 ++++++++++++++++
 tb/tb_multi_lifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_lifo_pkg.sv
// Shared types for the multi-channel LIFO: channel/count types, flag bundle, bench test ids.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package multi_lifo_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_AWIDTH = 8;

  // Channel index and occupancy count for the default configuration.
  typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;
  typedef logic [DEF_AWIDTH:0]           count_t;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic full;
    logic almost_full;
  } lifo_flags_t;

  typedef enum logic [2:0] {
    TC_RESET,
    TC_FILL_DRAIN,
    TC_OVERFLOW,
    TC_CROSS,
    TC_BYPASS,
    TC_FLUSH,
    TC_RANDOM
  } test_case_e;

  // Derive the four status flags from an occupancy count.
  function automatic lifo_flags_t calc_flags(input int cnt, input int depth,
                                             input int ae, input int af);
    lifo_flags_t f;
    f.empty        = (cnt == 0);
    f.almost_empty = (cnt <= ae);
    f.full         = (cnt == depth);
    f.almost_full  = (cnt >= depth - af);
    return f;
  endfunction

endpackage

// File: rtl/multi_lifo_ram.sv
// Simple dual-port storage shared by all LIFO channels: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en_i; write lands on the same edge.
// Backpressure: none; the caller guarantees legal addresses.
module multi_lifo_ram #(
  parameter int DWIDTH = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_dat_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_dat_o
);

  logic [DWIDTH-1:0] mem_q [2**ADDR_W];
  logic [DWIDTH-1:0] rd_dat_q;

  // Write port; contents are not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Registered read port, kept in the canonical form so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/multi_lifo.sv
// NUM_CH independent LIFO stacks carved out of one shared RAM, with per-channel counts and flags.
// Latency: popped word on q_o one cycle after the request; counts/flags update one cycle after.
// Backpressure: pushes to a full channel and pops from an empty channel are dropped (same-channel push+pop bypasses).
module multi_lifo #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int NUM_CH       = 4,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic                          wrreq_i,
  input  logic [$clog2(NUM_CH)-1:0]     wr_ch_i,
  input  logic [DWIDTH-1:0]             data_i,
  input  logic                          rdreq_i,
  input  logic [$clog2(NUM_CH)-1:0]     rd_ch_i,
  output logic [DWIDTH-1:0]             q_o,
  output logic                          q_valid_o,
  input  logic                          flush_i,
  input  logic [$clog2(NUM_CH)-1:0]     flush_ch_i,
  output logic [NUM_CH-1:0]             empty_o,
  output logic [NUM_CH-1:0]             almost_empty_o,
  output logic [NUM_CH-1:0]             full_o,
  output logic [NUM_CH-1:0]             almost_full_o,
  output logic [NUM_CH*(AWIDTH+1)-1:0]  usedw_o
);

  import multi_lifo_pkg::*;

  localparam int CHW   = $clog2(NUM_CH);
  localparam int CW    = AWIDTH + 1;
  localparam int DEPTH = 2**AWIDTH;
  localparam int RAW   = CHW + AWIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]     usedw_q [NUM_CH];
  logic [CW-1:0]     usedw_d [NUM_CH];
  logic [NUM_CH-1:0] empty_q, empty_d;
  logic [NUM_CH-1:0] aempty_q, aempty_d;
  logic [NUM_CH-1:0] full_q, full_d;
  logic [NUM_CH-1:0] afull_q, afull_d;
  logic              q_valid_q, q_valid_d;
  logic              byp_q, byp_d;
  logic [DWIDTH-1:0] byp_dat_q, byp_dat_d;
  logic [DWIDTH-1:0] hold_q, hold_d;

  logic              same_ch, wr_kill, rd_kill;
  logic              bypass, push_ok, pop_ok;
  logic [CW-1:0]     rd_top;
  logic [RAW-1:0]    wr_addr, rd_addr;
  logic [DWIDTH-1:0] ram_rd_dat;
  lifo_flags_t       fl;

  // Request arbitration: flush kills same-channel requests, same-channel push+pop bypasses the RAM.
  always_comb begin
    same_ch = wrreq_i && rdreq_i && (wr_ch_i == rd_ch_i);
    wr_kill = flush_i && (flush_ch_i == wr_ch_i);
    rd_kill = flush_i && (flush_ch_i == rd_ch_i);
    bypass  = !srst_i && same_ch && !wr_kill;
    push_ok = !srst_i && wrreq_i && !wr_kill && !same_ch && (usedw_q[wr_ch_i] != FULL_CNT);
    pop_ok  = !srst_i && rdreq_i && !rd_kill && !same_ch && (usedw_q[rd_ch_i] != '0);
    // Top of stack sits at usedw-1; the next free slot at usedw.
    rd_top  = usedw_q[rd_ch_i] - CW'(1);
    wr_addr = {wr_ch_i, usedw_q[wr_ch_i][AWIDTH-1:0]};
    rd_addr = {rd_ch_i, rd_top[AWIDTH-1:0]};
  end

  // Next per-channel counts and the flags derived from them, so flags never lag the count.
  always_comb begin
    fl       = '0;
    empty_d  = '0;
    aempty_d = '0;
    full_d   = '0;
    afull_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      usedw_d[i] = usedw_q[i];
      if (push_ok && (wr_ch_i == CHW'(i))) begin
        usedw_d[i] = usedw_q[i] + CW'(1);
      end
      if (pop_ok && (rd_ch_i == CHW'(i))) begin
        usedw_d[i] = usedw_q[i] - CW'(1);
      end
      if (flush_i && (flush_ch_i == CHW'(i))) begin
        usedw_d[i] = '0;
      end
      if (srst_i) begin
        usedw_d[i] = '0;
      end
      fl          = calc_flags(int'(usedw_d[i]), DEPTH, ALMOST_EMPTY, ALMOST_FULL);
      empty_d[i]  = fl.empty;
      aempty_d[i] = fl.almost_empty;
      full_d[i]   = fl.full;
      afull_d[i]  = fl.almost_full;
    end
  end

  // Output path: select RAM or bypass word while valid, otherwise replay the last word.
  always_comb begin
    q_valid_d = pop_ok || bypass;
    byp_d     = bypass;
    byp_dat_d = bypass ? data_i : byp_dat_q;
    q_o       = !q_valid_q ? hold_q : (byp_q ? byp_dat_q : ram_rd_dat);
    hold_d    = q_o;
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        usedw_q[i] <= '0;
      end
      empty_q   <= '1;
      aempty_q  <= '1;
      full_q    <= '0;
      afull_q   <= '0;
      q_valid_q <= 1'b0;
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
      hold_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        usedw_q[i] <= usedw_d[i];
      end
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      q_valid_q <= q_valid_d;
      byp_q     <= byp_d;
      byp_dat_q <= byp_dat_d;
      hold_q    <= hold_d;
    end
  end

  // Flatten the per-channel counts onto the output bus.
  always_comb begin
    usedw_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      usedw_o[i*CW +: CW] = usedw_q[i];
    end
  end

  assign q_valid_o      = q_valid_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;

  multi_lifo_ram #(
    .DWIDTH (DWIDTH),
    .ADDR_W (RAW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_addr),
    .wr_dat_i  (data_i),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rd_addr),
    .rd_dat_o  (ram_rd_dat)
  );

endmodule

// File: tb/tb_multi_lifo.sv
// Bench for multi_lifo: directed scenarios plus random traffic against a reference stack model.
// Latency: model expects results one cycle after each request.
// Backpressure: model drops pushes to full and pops from empty channels.
module tb_multi_lifo;

  import multi_lifo_pkg::*;

  localparam int NCH = 4;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int CW = AW + 1;

  logic              clk = 1'b0;
  logic              srst = 1'b0;
  logic              wrreq = 1'b0, rdreq = 1'b0, flush = 1'b0;
  ch_idx_t           wr_ch = '0, rd_ch = '0, flush_ch = '0;
  logic [15:0]       data_in = '0;
  logic [15:0]       q_o;
  logic              q_valid;
  logic [NCH-1:0]    empty, aempty, full, afull;
  logic [NCH*CW-1:0] usedw;

  int checks = 0;
  int errors = 0;
  test_case_e tc;

  // Reference model: one plain array-backed stack per channel.
  logic [15:0] stk [NCH][DEPTH];
  int          sz [NCH];
  logic [15:0] exp_q = '0;
  logic        exp_valid = 1'b0;
  bit          model_on = 1'b0;
  logic [NCH-1:0] e_emp, e_aemp, e_full, e_afull;

  multi_lifo #(
    .DWIDTH(16), .AWIDTH(AW), .NUM_CH(NCH), .ALMOST_FULL(2), .ALMOST_EMPTY(2)
  ) dut (
    .clk_i(clk), .srst_i(srst),
    .wrreq_i(wrreq), .wr_ch_i(wr_ch), .data_i(data_in),
    .rdreq_i(rdreq), .rd_ch_i(rd_ch),
    .q_o(q_o), .q_valid_o(q_valid),
    .flush_i(flush), .flush_ch_i(flush_ch),
    .empty_o(empty), .almost_empty_o(aempty), .full_o(full), .almost_full_o(afull),
    .usedw_o(usedw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (test %s) at %0t: got 0x%0h, expected 0x%0h", name, tc.name(), $time, act, exp);
    end
  endtask

  function automatic logic [31:0] uw(input int ch);
    return 32'(usedw[ch*CW +: CW]);
  endfunction

  // Apply the rules of the block to the reference stacks for the inputs seen at this edge.
  task automatic model_step();
    bit wa, ra;
    if (srst) begin
      for (int i = 0; i < NCH; i++) sz[i] = 0;
      exp_valid = 1'b0;
      exp_q = '0;
      model_on = 1'b1;
    end else begin
      wa = wrreq && !(flush && flush_ch == wr_ch);
      ra = rdreq && !(flush && flush_ch == rd_ch);
      exp_valid = 1'b0;
      if (wa && ra && wr_ch == rd_ch) begin
        exp_valid = 1'b1;
        exp_q = data_in;
      end else begin
        if (ra && sz[rd_ch] > 0) begin
          sz[rd_ch]--;
          exp_q = stk[rd_ch][sz[rd_ch]];
          exp_valid = 1'b1;
        end
        if (wa && sz[wr_ch] < DEPTH) begin
          stk[wr_ch][sz[wr_ch]] = data_in;
          sz[wr_ch]++;
        end
      end
      if (flush) sz[flush_ch] = 0;
    end
  endtask

  // One clock of stimulus; requests are removed again shortly after the edge.
  task automatic drive(input bit w, input int wc, input logic [15:0] d,
                       input bit r, input int rc,
                       input bit f = 1'b0, input int fc = 0, input bit rst = 1'b0);
    wrreq = w; wr_ch = 2'(wc); data_in = d;
    rdreq = r; rd_ch = 2'(rc);
    flush = f; flush_ch = 2'(fc);
    srst = rst;
    @(posedge clk);
    model_step();
    #1;
    wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0; srst = 1'b0;
  endtask

  task automatic push(input int ch, input logic [15:0] d);
    drive(1'b1, ch, d, 1'b0, 0);
  endtask

  task automatic pop(input int ch);
    drive(1'b0, 0, '0, 1'b1, ch);
  endtask

  // Cycle-by-cycle comparison of every output against the reference model.
  always @(negedge clk) begin
    if (model_on) begin
      for (int c = 0; c < NCH; c++) begin
        e_emp[c]   = (sz[c] == 0);
        e_aemp[c]  = (sz[c] <= 2);
        e_full[c]  = (sz[c] == DEPTH);
        e_afull[c] = (sz[c] >= DEPTH - 2);
        chk($sformatf("model usedw ch%0d", c), uw(c), 32'(sz[c]));
      end
      chk("model q_valid", 32'(q_valid), 32'(exp_valid));
      chk("model q", 32'(q_o), 32'(exp_q));
      chk("model empty", 32'(empty), 32'(e_emp));
      chk("model almost_empty", 32'(aempty), 32'(e_aemp));
      chk("model full", 32'(full), 32'(e_full));
      chk("model almost_full", 32'(afull), 32'(e_afull));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w, r, f;
    // Reset state.
    tc = TC_RESET;
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("reset usedw", 32'(usedw), 32'h0);
    chk("reset empty", 32'(empty), 32'hF);
    chk("reset almost_empty", 32'(aempty), 32'hF);
    chk("reset full", 32'(full), 32'h0);
    chk("reset almost_full", 32'(afull), 32'h0);
    chk("reset q", 32'(q_o), 32'h0);
    chk("reset q_valid", 32'(q_valid), 32'h0);

    // Fill and drain channel 2.
    tc = TC_FILL_DRAIN;
    for (int k = 1; k <= 8; k++) push(2, 16'(k));
    chk("fill full[2]", 32'(full[2]), 32'h1);
    chk("fill usedw ch2", uw(2), 32'd8);
    chk("fill almost_full[2]", 32'(afull[2]), 32'h1);
    for (int k = 0; k < 8; k++) begin
      pop(2);
      chk("drain q_valid", 32'(q_valid), 32'h1);
      chk("drain q", 32'(q_o), 32'(8 - k));
    end
    chk("drain empty[2]", 32'(empty[2]), 32'h1);

    // Overflow and underflow on channel 1.
    tc = TC_OVERFLOW;
    for (int k = 1; k <= 10; k++) push(1, 16'(16'h0100 + k));
    chk("overflow usedw ch1", uw(1), 32'd8);
    for (int k = 0; k < 8; k++) begin
      pop(1);
      chk("underflow q", 32'(q_o), 32'(16'h0108 - k));
    end
    pop(1);
    chk("underflow 9th q_valid", 32'(q_valid), 32'h0);
    chk("underflow q holds", 32'(q_o), 32'h0101);

    // Push and pop on different channels in one cycle.
    tc = TC_CROSS;
    push(3, 16'h5555);
    drive(1'b1, 0, 16'hAAAA, 1'b1, 3);
    chk("cross q", 32'(q_o), 32'h5555);
    chk("cross q_valid", 32'(q_valid), 32'h1);
    chk("cross usedw ch0", uw(0), 32'd1);
    chk("cross usedw ch3", uw(3), 32'd0);

    // Same-channel bypass on empty and on full channels.
    tc = TC_BYPASS;
    drive(1'b1, 1, 16'h1234, 1'b1, 1);
    chk("bypass empty q", 32'(q_o), 32'h1234);
    chk("bypass empty q_valid", 32'(q_valid), 32'h1);
    chk("bypass empty usedw ch1", uw(1), 32'd0);
    for (int k = 0; k < 8; k++) push(1, 16'(16'h0300 + k));
    drive(1'b1, 1, 16'h4321, 1'b1, 1);
    chk("bypass full q", 32'(q_o), 32'h4321);
    chk("bypass full usedw ch1", uw(1), 32'd8);
    pop(1);
    chk("after bypass pop q", 32'(q_o), 32'h0307);

    // Flush overriding push and pop.
    tc = TC_FLUSH;
    for (int k = 0; k < 4; k++) push(0, 16'(16'h0010 + k));
    push(2, 16'h0022);
    push(2, 16'h0023);
    chk("pre-flush usedw ch0", uw(0), 32'd5);
    drive(1'b1, 0, 16'hBEEF, 1'b0, 0, 1'b1, 0);
    chk("flush usedw ch0", uw(0), 32'd0);
    chk("flush empty[0]", 32'(empty[0]), 32'h1);
    chk("flush ch2 intact", uw(2), 32'd2);
    chk("flush ch1 intact", uw(1), 32'd7);
    drive(1'b1, 3, 16'h0033, 1'b1, 2, 1'b1, 2);
    chk("flush pop q_valid", 32'(q_valid), 32'h0);
    chk("flush usedw ch2", uw(2), 32'd0);
    chk("flush other push ch3", uw(3), 32'd1);
    pop(3);
    chk("flush other pop q", 32'(q_o), 32'h0033);

    // Random traffic with a reset in the middle.
    tc = TC_RANDOM;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 4);
      if (i == 150) begin
        drive(w, $urandom_range(0, 3), 16'($urandom), r, $urandom_range(0, 3),
              f, $urandom_range(0, 3), 1'b1);
        chk("mid reset usedw", 32'(usedw), 32'h0);
        chk("mid reset empty", 32'(empty), 32'hF);
        chk("mid reset full", 32'(full), 32'h0);
        chk("mid reset q_valid", 32'(q_valid), 32'h0);
        chk("mid reset q", 32'(q_o), 32'h0);
      end else begin
        drive(w, $urandom_range(0, 3), 16'($urandom), r, $urandom_range(0, 3),
              f, $urandom_range(0, 3));
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
